// File: rtl/softmax_pkg.sv
// Constants and state type shared between the exponent accumulator and the divider.
package softmax_pkg;
   localparam int DW = 16;
   localparam int SW = 32;

   typedef enum logic {ACCUM, REPLAY} state_t;
endpackage

// File: rtl/softmax_buf_ram.sv
// Element buffer: one write port, one synchronous read port with write-first bypass.
module softmax_buf_ram #(
   parameter int DEPTH = 16,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DW-1:0]            rd_data
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Bypass lets a one-element vector be replayed the cycle after it is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               rd_data <= '0;
      else if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
      else                                   rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/softmax_exp_accumulator.sv
// Buffers one softmax vector of exponentials, sums it, then replays each element
// with the frozen sum as a numerator/divisor pair for the divider.
module softmax_exp_accumulator #(
   parameter int DEPTH = 16,
   parameter int DW    = softmax_pkg::DW,
   parameter int SW    = softmax_pkg::SW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_x,
   output logic [SW-1:0] out_y,
   output logic          out_last,
   output logic          len_err,
   output logic          sum_zero
);
   import softmax_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   state_t        state, state_nxt;
   logic [CW-1:0] wr_cnt, rd_cnt, len;
   logic [SW-1:0] sum;
   logic          run;
   logic          accept, xfer, full, close;
   logic [AW-1:0] rd_addr;

   assign accept = in_valid && in_ready;
   assign xfer   = out_valid && out_ready;
   assign full   = (wr_cnt == CW'(DEPTH - 1));
   assign close  = accept && (in_last || full);
   assign out_y  = sum;

   // Read one address ahead on a transfer so the next element is ready without a bubble.
   always_comb begin
      rd_addr = rd_cnt[AW-1:0];
      if (xfer) rd_addr = out_last ? '0 : rd_cnt[AW-1:0] + AW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      sum_zero  = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = run;
            if (close) state_nxt = REPLAY;
         end
         REPLAY: begin
            out_valid = 1'b1;
            out_last  = (rd_cnt == len - CW'(1));
            sum_zero  = (sum == '0);
            if (xfer && out_last) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run     <= 1'b0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         len     <= '0;
         sum     <= '0;
         len_err <= 1'b0;
      end else begin
         run     <= 1'b1;
         len_err <= accept && full && !in_last;
         if (accept) begin
            sum    <= sum + SW'(in_data);
            wr_cnt <= wr_cnt + CW'(1);
         end
         if (close) len <= wr_cnt + CW'(1);
         if (xfer) begin
            if (out_last) begin
               sum    <= '0;
               wr_cnt <= '0;
               rd_cnt <= '0;
            end else begin
               rd_cnt <= rd_cnt + CW'(1);
            end
         end
      end
   end

   softmax_buf_ram #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_addr (wr_cnt[AW-1:0]),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (out_x)
   );
endmodule

// File: tb/tb_softmax_exp_accumulator.sv
// Self-checking bench: directed vectors plus random vectors against a sum/replay model.
module tb_softmax_exp_accumulator;
   localparam int DEPTH = 16;
   localparam int DW    = 16;
   localparam int SW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_last;
   logic [DW-1:0] in_data;
   logic          out_valid, out_ready, out_last, len_err, sum_zero;
   logic [DW-1:0] out_x;
   logic [SW-1:0] out_y;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] vals [DEPTH];

   always #5 clk = ~clk;

   softmax_exp_accumulator #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .SW    (SW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_last  (out_last),
      .len_err   (len_err),
      .sum_zero  (sum_zero)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic send_vec(input int n, input bit use_last, input bit gaps);
      for (int i = 0; i < n; i++) begin
         bit done;
         int guard;
         done  = 1'b0;
         guard = 0;
         while (!done) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               in_data  = DW'($urandom);
               in_last  = 1'b0;
            end else begin
               in_valid = 1'b1;
               in_data  = vals[i];
               in_last  = use_last && (i == n - 1);
               if (in_ready) done = 1'b1;
            end
            guard++;
            if (!done && guard > 20) begin
               check("in_ready_timeout", 32'(in_ready), 32'd1);
               done = 1'b1;
            end
         end
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: ready taken from pat (LSB first)
   task automatic recv_vec(input int n, input bit use_last, input int mode, input logic [31:0] pat);
      int            len, idx, cyc;
      logic [SW-1:0] s;
      bit            trunc;
      len   = n;
      s     = '0;
      for (int i = 0; i < len; i++) s = s + SW'(vals[i]);
      trunc = !use_last && (n == DEPTH);
      idx   = 0;
      cyc   = 0;
      while (idx < len && cyc < 200) begin
         @(negedge clk);
         if (cyc == 0) begin
            check("first_valid_latency", 32'(out_valid), 32'd1);
            check("len_err", 32'(len_err), 32'(trunc));
         end else begin
            check("len_err_quiet", 32'(len_err), 32'd0);
         end
         check("in_ready_replay", 32'(in_ready), 32'd0);
         check("out_valid", 32'(out_valid), 32'd1);
         check("out_x", 32'(out_x), 32'(vals[idx]));
         check("out_y", out_y, s);
         check("out_last", 32'(out_last), 32'(idx == len - 1));
         check("sum_zero", 32'(sum_zero), 32'(s == '0));
         in_valid = 1'($urandom_range(0, 1));
         in_data  = DW'($urandom);
         in_last  = 1'($urandom_range(0, 1));
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (cyc < 32) ? pat[cyc] : 1'b1;
         endcase
         if (out_ready) idx++;
         cyc++;
      end
      if (idx < len) check("replay_timeout", 32'(idx), 32'(len));
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("in_ready_after", 32'(in_ready), 32'd1);
      check("out_valid_after", 32'(out_valid), 32'd0);
      check("len_err_after", 32'(len_err), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_x"},     32'(out_x),     32'd0);
      check({tag, "_out_y"},     out_y,          32'd0);
      check({tag, "_out_last"},  32'(out_last),  32'd0);
      check({tag, "_len_err"},   32'(len_err),   32'd0);
      check({tag, "_sum_zero"},  32'(sum_zero),  32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bit use_last;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_post_reset", 32'(in_ready), 32'd1);

      vals[0] = 16'd100; vals[1] = 16'd200; vals[2] = 16'd300; vals[3] = 16'd400;
      send_vec(4, 1'b1, 1'b0);
      recv_vec(4, 1'b1, 0, 32'd0);

      vals[0] = 16'hFFFF;
      send_vec(1, 1'b1, 1'b0);
      recv_vec(1, 1'b1, 0, 32'd0);

      for (int i = 0; i < DEPTH; i++) vals[i] = 16'hFFFF;
      send_vec(DEPTH, 1'b0, 1'b0);
      recv_vec(DEPTH, 1'b0, 0, 32'd0);

      vals[0] = 16'd5; vals[1] = 16'd7;
      send_vec(2, 1'b1, 1'b0);
      recv_vec(2, 1'b1, 2, 32'b1001);

      vals[0] = 16'd0; vals[1] = 16'd0; vals[2] = 16'd0;
      send_vec(3, 1'b1, 1'b0);
      recv_vec(3, 1'b1, 0, 32'd0);

      vals[0] = 16'd9; vals[1] = 16'd9; vals[2] = 16'd9; vals[3] = 16'd9;
      send_vec(2, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
      vals[0] = 16'd1; vals[1] = 16'd2;
      send_vec(2, 1'b1, 1'b0);
      recv_vec(2, 1'b1, 0, 32'd0);

      repeat (25) begin
         n        = int'($urandom_range(1, DEPTH));
         use_last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            for (int i = 0; i < n; i++) vals[i] = '0;
         end else begin
            for (int i = 0; i < n; i++)
               vals[i] = ($urandom_range(0, 3) == 0) ? DW'(0) : DW'($urandom);
         end
         send_vec(n, use_last, 1'b1);
         recv_vec(n, use_last, 1, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/softmax_exp_accumulator.md
# softmax_exp_accumulator

Upstream feeder for the exact array divider in the approximate-softmax datapath. Accepts a stream of 16-bit exponential values for one softmax vector, buffers them, and accumulates their 32-bit sum. Once the vector closes, replays each buffered value as the divider numerator alongside the frozen sum as the divisor. One numerator/divisor pair is presented per handshake.

## Interface
- DEPTH, 16, maximum elements per vector (power of two, 2..256)
- DW, 16, element width; matches divider numerator X
- SW, 32, sum width; matches divider divisor Y
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream element valid
- in_ready  output  1  block can accept an element
- in_data  input  DW  exponential value
- in_last  input  1  final element of the vector
- out_valid  output  1  numerator/divisor pair valid
- out_ready  input  1  divider-side register accepts the pair
- out_x  output  DW  buffered element, feeds divider X
- out_y  output  SW  vector sum, feeds divider Y
- out_last  output  1  pair is the vector's final element
- len_err  output  1  one-cycle pulse: vector truncated at DEPTH
- sum_zero  output  1  sum is zero during replay (divide-by-zero warning)

## Operation
- States: ACCUM (reset state) and REPLAY.
- **ACCUM**
  - in_ready=1; out_valid=0.
  - On in_valid&in_ready: buf[wr_cnt]<=in_data; sum<=sum+in_data (zero-extended to SW); wr_cnt++.
  - Transition to REPLAY when the accepted beat has in_last=1 or wr_cnt==DEPTH-1.
  - Latch len=wr_cnt+1.
  - If the DEPTH-th beat is accepted without in_last: vector ends there and len_err pulses in the following cycle.
- **REPLAY**
  - in_ready=0; out_valid=1; out_x=buf[rd_cnt]; out_y=sum.
  - out_last=(rd_cnt==len-1); sum_zero=(sum==0).
  - On out_valid&out_ready: rd_cnt++.
  - On a transfer with out_last=1: clear sum, wr_cnt, rd_cnt; return to ACCUM.
- Arithmetic: the sum cannot overflow for DEPTH≤65537. The SW=32 sum is exact; no saturation logic.
- A zero sum is passed through unchanged. sum_zero is informational; downstream decides.
- Reset (any time, including mid-vector or mid-replay):
  - State=ACCUM; sum, wr_cnt, rd_cnt, len=0.
  - All outputs 0 except in_ready, which is 0 during reset assertion and 1 the first cycle after deassertion.
  - Buffer contents are not cleared.

## Timing
- Input throughput: 1 element/cycle in ACCUM.
- Latency: first out_valid is asserted in the cycle after the last input beat is accepted.
- Output throughput: 1 pair/cycle while out_ready=1.
- in_ready returns high in the cycle after the out_last transfer. Minimum dead time between vectors is 1 cycle.
- out_x, out_y, out_last, sum_zero are registered or read from synchronous-read RAM with lookahead. They are stable while out_valid&!out_ready.
- out_valid never drops without a transfer.
- in_valid is ignored when in_ready=0; the upstream stage must hold its data.

## Structure
- Shared package softmax_pkg: DW, SW constants (shared with the divider), state enum {ACCUM, REPLAY}.
- Sub-module softmax_buf_ram: DEPTH×DW single-write, single-read, synchronous-read buffer with address-ahead read.
- Counters are $clog2(DEPTH)+1 bits wide so that len==DEPTH is representable.

## Test plan
- Vector {100,200,300,400}, last on 4th; out_ready=1 → out pairs (100,1000),(200,1000),(300,1000),(400,1000). out_last on 4th pair; first out_valid 1 cycle after last input.
- Single element 0xFFFF with last → one pair (0xFFFF,0x0000FFFF) with out_last=1; in_ready=0 for exactly 1 cycle during replay.
- 16 × 0xFFFF, no last, DEPTH=16 → len_err pulse; out_y=0x000FFFF0 on all 16 pairs.
- Vector {5,7} with out_ready toggling 1,0,0,1 → out_x/out_y held stable during stalls; no pairs dropped or duplicated.
- Vector {0,0,0} → sum_zero=1 and out_y=0 on all three pairs.
- rst asserted after 2 of 4 accepted beats, then new vector {1,2} → pairs (1,3),(2,3); no residue from the aborted vector.
